// File: rtl/frame_align_pkg.sv
// frame_align_pkg: shared FSM state type, counter widths and size helpers for the SOF frame aligner.
package frame_align_pkg;
    typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} fa_state_t;
    localparam int WRAP_W = 8;
    localparam int ERR_W = 16;
    function automatic int slip_width(input int max_slip);
        return (max_slip > 1) ? $clog2(max_slip) : 1;
    endfunction
    function automatic int mxsbits(input int mxio, input int word_size);
        return mxio * word_size;
    endfunction
    function automatic int hist_width(input int max_slip, input int word_size);
        return (2 * max_slip > max_slip + word_size) ? 2 * max_slip : max_slip + word_size;
    endfunction
endpackage

// File: rtl/bitslip_delay.sv
// bitslip_delay: one DDR lane history with a slip-selected WORD_SIZE-bit frame window (bit 0 earliest).
module bitslip_delay import frame_align_pkg::*; #(
    parameter int WORD_SIZE = 8,
    parameter int MAX_SLIP = 16
) (
    input  logic fastclock,
    input  logic reset,
    input  logic d0,
    input  logic d1,
    input  logic [slip_width(MAX_SLIP)-1:0] slip,
    output logic [WORD_SIZE-1:0] window
);
    localparam int HW = hist_width(MAX_SLIP, WORD_SIZE);
    localparam int IW = $clog2(HW + 2);
    logic [HW-1:0] hist;
    logic [HW+1:0] full;
    // Newest bit (current d1) sits at index 0, so a larger index means an older bit
    assign full = {hist, d0, d1};
    // Shift both DDR bits in each cycle, d0 ahead of d1
    always_ff @(posedge fastclock)
        hist <= reset ? '0 : full[HW-1:0];
    for (genvar k = 0; k < WORD_SIZE; k++) begin : g_win
        assign window[k] = full[IW'(slip) + IW'(WORD_SIZE - 1 - k)];
    end
endmodule

// File: rtl/sof_frame_aligner_fsm.sv
// sof_frame_aligner_fsm: slips S-bit lanes and SOF together until SOF lands on frame bit 0, with lock/unlock hysteresis.
// Define FRAME_ALIGNER_ERRCNT_EN to build the err_cnt/search_wraps statistics; otherwise both read 0.
module sof_frame_aligner_fsm import frame_align_pkg::*; #(
    parameter int MXIO = 8,
    parameter int WORD_SIZE = 8,
    parameter int MAX_SLIP = 16,
    parameter int LOCK_COUNT = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic fastclock,
    input  logic reset,
    input  logic [MXIO-1:0] d0,
    input  logic [MXIO-1:0] d1,
    input  logic sof_d0,
    input  logic sof_d1,
    input  logic frame_strobe,
    input  logic mask,
    output logic [mxsbits(MXIO, WORD_SIZE)-1:0] sbits,
    output logic sbits_valid,
    output logic locked,
    output logic alignment_error,
    output logic [slip_width(MAX_SLIP)-1:0] slip,
    output logic [WRAP_W-1:0] search_wraps,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int MXSBITS = mxsbits(MXIO, WORD_SIZE);
    localparam int SW = slip_width(MAX_SLIP);
    localparam int CW = $clog2((LOCK_COUNT > UNLOCK_COUNT ? LOCK_COUNT : UNLOCK_COUNT) + SETTLE_FRAMES + 1);
    fa_state_t state, state_nxt;
    logic [MXIO:0] all_d0, all_d1;
    logic [MXSBITS-1:0] data_win;
    logic [WORD_SIZE-1:0] sof_win;
    logic [CW-1:0] good_cnt, bad_cnt, settle_cnt;
    logic prev_last, good, slip_step, bad_locked;
    assign all_d0 = {sof_d0, d0};
    assign all_d1 = {sof_d1, d1};
    // SOF rides in the top lane so it is delayed exactly like the data
    for (genvar i = 0; i <= MXIO; i++) begin : g_lane
        logic [WORD_SIZE-1:0] w;
        bitslip_delay #(.WORD_SIZE(WORD_SIZE), .MAX_SLIP(MAX_SLIP)) u_slip (
            .fastclock(fastclock),
            .reset(reset),
            .d0(all_d0[i]),
            .d1(all_d1[i]),
            .slip(slip),
            .window(w)
        );
        if (i < MXIO) begin : g_data
            assign data_win[i*WORD_SIZE +: WORD_SIZE] = w;
        end else begin : g_sof
            assign sof_win = w;
        end
    end
    // A frame is good only when SOF opens it and did not close the previous one
    assign good = sof_win[0] & ~prev_last;
    // State register
    always_ff @(posedge fastclock)
        state <= reset ? SEARCH : state_nxt;
    // Next state, advanced only on frame strobes
    always_comb begin
        state_nxt = state;
        if (frame_strobe)
            unique case (state)
                SEARCH:  state_nxt = !good ? SETTLE : (good_cnt == CW'(LOCK_COUNT - 1)) ? LOCKED : SEARCH;
                SETTLE:  state_nxt = (settle_cnt == CW'(SETTLE_FRAMES - 1)) ? SEARCH : SETTLE;
                LOCKED:  state_nxt = (!good && bad_cnt == CW'(UNLOCK_COUNT - 1)) ? SEARCH : LOCKED;
                default: state_nxt = SEARCH;
            endcase
    end
    // State-decoded outputs and strobe-qualified events
    always_comb begin
        locked = state == LOCKED;
        slip_step = frame_strobe && state == SEARCH && !good;
        bad_locked = frame_strobe && state == LOCKED && !good;
    end
    // Hysteresis counters, slip and previous-frame SOF tail, all stepped per frame
    always_ff @(posedge fastclock)
        if (reset) begin
            good_cnt <= '0;
            bad_cnt <= '0;
            settle_cnt <= '0;
            slip <= '0;
            prev_last <= 1'b0;
        end else if (frame_strobe) begin
            prev_last <= sof_win[WORD_SIZE-1];
            good_cnt <= (state == SEARCH && state_nxt == SEARCH) ? good_cnt + 1'b1 : '0;
            bad_cnt <= (state == LOCKED && state_nxt == LOCKED && !good) ? bad_cnt + 1'b1 : '0;
            settle_cnt <= (state == SETTLE && state_nxt == SETTLE) ? settle_cnt + 1'b1 : '0;
            slip <= !slip_step ? slip : (slip == SW'(MAX_SLIP - 1)) ? '0 : slip + 1'b1;
        end
    // Registered frame outputs; data only passes while locked and unmasked
    always_ff @(posedge fastclock)
        if (reset) begin
            sbits <= '0;
            sbits_valid <= 1'b0;
            alignment_error <= 1'b0;
        end else begin
            sbits_valid <= frame_strobe;
            alignment_error <= bad_locked;
            sbits <= (mask || state_nxt != LOCKED) ? '0 : frame_strobe ? data_win : sbits;
        end
`ifdef FRAME_ALIGNER_ERRCNT_EN
    logic slip_wrap;
    assign slip_wrap = slip_step && slip == SW'(MAX_SLIP - 1);
    // Saturating statistics for the trigger cluster logic
    always_ff @(posedge fastclock)
        if (reset) begin
            err_cnt <= '0;
            search_wraps <= '0;
        end else begin
            if (bad_locked && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (slip_wrap && search_wraps != '1) search_wraps <= search_wraps + 1'b1;
        end
`else
    assign err_cnt = '0;
    assign search_wraps = '0;
`endif
endmodule

// File: doc/sof_frame_aligner_fsm.md
Name: sof_frame_aligner_fsm

Overview:
Parametrised per-VFAT trigger frame aligner that runs entirely in the fastclock domain. It takes MXIO DDR S-bit lanes plus a DDR start-of-frame (SOF) lane and bit-slips all lanes together until SOF lands on frame bit 0. It then deserialises WORD_SIZE bits per lane per frame. A lock/unlock hysteresis FSM replaces free-running toggle search and reports error statistics upstream to the trigger cluster logic.

Parameters:
MXIO, 8, number of S-bit data lanes.
WORD_SIZE, 8, bits per lane per frame; even, 4..16. Frame length is WORD_SIZE/2 fastclock cycles.
MXSBITS, MXIO*WORD_SIZE, output width (derived, not overridable).
MAX_SLIP, 16, bit-slip search range in bits. Delay values are 0..MAX_SLIP-1.
LOCK_COUNT, 8, consecutive good frames needed to declare lock.
UNLOCK_COUNT, 4, consecutive bad frames while locked that drop lock.
SETTLE_FRAMES, 2, frames ignored after every slip change.

Ports:
fastclock  in  1  DDR bit clock (one bit on each of d0/d1 per cycle).
reset  in  1  synchronous, active-high.
d0  in  MXIO  earlier bit of each lane per fastclock.
d1  in  MXIO  later bit of each lane per fastclock.
sof_d0  in  1  earlier SOF bit.
sof_d1  in  1  later SOF bit.
frame_strobe  in  1  one-cycle pulse every WORD_SIZE/2 cycles marking the 40 MHz boundary.
mask  in  1  forces sbits to zero; alignment keeps running.
sbits  out  MXSBITS  deserialised frame. sbits[ipin*WORD_SIZE+k] is bit k (k=0 earliest) of lane ipin.
sbits_valid  out  1  one-cycle pulse, 1 cycle after frame_strobe.
locked  out  1  FSM in LOCKED state.
alignment_error  out  1  one-cycle pulse per bad frame while LOCKED.
slip  out  $clog2(MAX_SLIP)  current bit delay.
search_wraps  out  8  count of full slip sweeps without lock; saturating.
err_cnt  out  16  bad frames seen while LOCKED; saturating.

Behaviour:
- Reset: FSM=SEARCH; slip=0; all counters 0; sbits=0; sbits_valid=0; locked=0; alignment_error=0; internal shift history cleared.
- Serial order per lane: d0 precedes d1. The bit stream is delayed by `slip` bits. Odd slips pair the previous cycle's d1 with the current d0. SOF is delayed identically to the data.
- Frame capture: on frame_strobe, latch the last WORD_SIZE delayed bits of each lane plus the SOF lane. Register the outputs on the next cycle.
- sbits are 0 when reset, mask, or !locked. sbits_valid still pulses while masked.
- Good frame: captured SOF bit 0 = 1 AND SOF bit WORD_SIZE-1 of the previous frame = 0. Any other pattern is a bad frame.
- FSM, evaluated only on frame_strobe:
  - SEARCH:
    - good frame: good_cnt++.
    - good_cnt reaches LOCK_COUNT: go to LOCKED.
    - bad frame: good_cnt=0, slip++, go to SETTLE.
  - slip wraps from MAX_SLIP-1 to 0: search_wraps++ (saturates at 255).
  - SETTLE: stay for SETTLE_FRAMES strobes, ignoring frame quality, then go to SEARCH.
  - LOCKED:
    - bad frame: pulse alignment_error, err_cnt++ (saturates at 65535), bad_cnt++.
    - good frame: bad_cnt=0.
    - bad_cnt reaches UNLOCK_COUNT: go to SEARCH with slip unchanged and locked deasserted that same cycle.
- slip never changes while LOCKED.
- Reset mid-frame: takes effect on the next edge. The first strobe after reset is evaluated normally.
- Strobe during the reset cycle is ignored.

Optional Feature:
- FRAME_ALIGNER_ERRCNT_EN.
- Defined: err_cnt and search_wraps counters are implemented as specified.
- Undefined: both outputs are tied to 0 and the counters are not synthesised. FSM and alignment_error are unchanged.

Decomposition:
- Package frame_align_pkg:
  - FSM state enum: SEARCH, SETTLE, LOCKED.
  - Width constants: slip width from MAX_SLIP, counter widths 8/16.
  - Helper function computing MXSBITS.
- Sub-module bitslip_delay:
  - One DDR lane with a 2*MAX_SLIP-bit history and slip-indexed WORD_SIZE-bit window output.
  - Instantiated MXIO+1 times (data lanes plus SOF).

Test Plan:
- SOF rising edge and data pattern 0xA5 per lane injected 5 bits late, defaults → slip settles at 5, locked after 8 good frames, sbits lane0 byte = 0xA5, locked stays 1 for 100 frames.
- Locked, then 3 corrupted SOF frames and a good one → 3 alignment_error pulses, err_cnt=3, locked stays 1.
- Locked, then 4 consecutive bad frames → locked drops on 4th strobe, FSM=SEARCH, slip unchanged; re-lock after 8 good frames.
- SOF held constant 0 → slip cycles 0..15 with a 3-frame step (1 evaluation + 2 settle); search_wraps=1 after 48 frames; sbits stay 0.
- mask=1 while locked → sbits=0, sbits_valid still pulses, locked stays 1; reset asserted mid-search → all outputs 0, slip=0 next cycle.
- FRAME_ALIGNER_ERRCNT_EN undefined with the error-injection scenario → err_cnt=0, alignment_error pulses unchanged.
